// File: rtl/counter4_checker_pkg.sv
// Shared definitions for the counter4 stream checker.
// Contents: lock FSM state encoding, all-ones helper for a given bus width.
// Imported by counter4_checker and sat_counter.
package counter4_checker_pkg;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // All-ones value for a bus of width w, returned in a 32-bit container.
  function automatic logic [31:0] all_ones(input int unsigned w);
    if (w >= 32) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/counter4_checker_sat_counter.sv
// Statistic counter that either saturates at all-ones or wraps, chosen by SATURATE.
// Ports: i_clk/i_rst (sync, active-high), i_inc increment enable, o_count value.
// Registered output: an increment on edge N is visible after edge N.
module sat_counter
  import counter4_checker_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] L_MAX = WIDTH'(all_ones(WIDTH));

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_inc) begin
      if (!(SATURATE && (r_count == L_MAX))) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/counter4_checker.sv
// Receive-side checker: locks onto an incrementing count/carry stream and flags breaks.
// Ports: CLK, RESET (sync, active-high), I/CIN observed stream; LOCKED, ERR pulse,
//        ERR_COUNT (saturating) and WRAPS (wrapping) statistics. Outputs lag the sample by one cycle.
module counter4_checker
  import counter4_checker_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int LOCK_COUNT  = 4,
  parameter int UNLOCK_ERRS = 2,
  parameter int STAT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [WIDTH-1:0]      I,
  input  logic                  CIN,
  output logic                  LOCKED,
  output logic                  ERR,
  output logic [STAT_WIDTH-1:0] ERR_COUNT,
  output logic [STAT_WIDTH-1:0] WRAPS
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_ERRS + 1);
  localparam logic [WIDTH-1:0] L_ONES = WIDTH'(all_ones(WIDTH));

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_prev;
  logic             r_prev_valid;
  logic             r_prev_good;
  logic [GW-1:0]    r_good_run;
  logic [GW-1:0]    w_good_run_nxt;
  logic [BW-1:0]    r_bad_run;
  logic [BW-1:0]    w_bad_run_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic             w_wrap_inc;
  logic [WIDTH-1:0] w_prev_inc;
  logic             w_carry_ok;
  logic             w_good;

  assign w_prev_inc = r_prev + 1'b1;
  assign w_carry_ok = (CIN == (I == L_ONES));
  assign w_good     = r_prev_valid && (I == w_prev_inc) && w_carry_ok;

  always_comb begin
    w_state_nxt    = r_state;
    w_good_run_nxt = r_good_run;
    w_bad_run_nxt  = r_bad_run;
    w_err_nxt      = 1'b0;
    w_wrap_inc     = 1'b0;
    // The first sample after reset only primes prev; nothing is classified.
    if (r_prev_valid) begin
      case (r_state)
        ST_HUNT: begin
          if (w_good) begin
            if (int'(r_good_run) + 1 >= LOCK_COUNT) begin
              w_state_nxt    = ST_LOCKED;
              w_good_run_nxt = '0;
              w_bad_run_nxt  = '0;
            end else begin
              w_good_run_nxt = r_good_run + 1'b1;
            end
          end else begin
            w_good_run_nxt = '0;
          end
        end
        ST_LOCKED: begin
          if (w_good) begin
            w_bad_run_nxt = '0;
            // A wrap is only an in-sequence transition if the all-ones sample
            // itself was good; a 15 with a bad carry followed by 0 is not counted.
            w_wrap_inc    = r_prev_good && (r_prev == L_ONES) && (I == '0);
          end else begin
            w_err_nxt = 1'b1;
            if (int'(r_bad_run) + 1 >= UNLOCK_ERRS) begin
              w_state_nxt    = ST_HUNT;
              w_good_run_nxt = '0;
              w_bad_run_nxt  = '0;
            end else begin
              w_bad_run_nxt = r_bad_run + 1'b1;
            end
          end
        end
        default: w_state_nxt = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= ST_HUNT;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_prev_good  <= 1'b0;
      r_good_run   <= '0;
      r_bad_run    <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      // prev always follows the bus so the checker resyncs to a new sequence.
      r_prev       <= I;
      r_prev_valid <= 1'b1;
      r_prev_good  <= w_good;
      r_good_run   <= w_good_run_nxt;
      r_bad_run    <= w_bad_run_nxt;
      r_err        <= w_err_nxt;
    end
  end

  sat_counter #(.WIDTH(STAT_WIDTH), .SATURATE(1'b1)) u_err_count (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_inc   (w_err_nxt),
    .o_count (ERR_COUNT)
  );

  sat_counter #(.WIDTH(STAT_WIDTH), .SATURATE(1'b0)) u_wraps (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_inc   (w_wrap_inc),
    .o_count (WRAPS)
  );

  assign LOCKED = (r_state == ST_LOCKED);
  assign ERR    = r_err;

endmodule

// File: tb/tb_counter4_checker.sv
// Directed bench for counter4_checker: lock, reset, skip, carry glitch, stuck bus,
// and ERR_COUNT saturation on a second instance with LOCK_COUNT=1.
module tb_counter4_checker;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] I;
  logic       CIN;
  logic       LOCKED, ERR;
  logic [7:0] ERR_COUNT, WRAPS;

  logic       s_RESET;
  logic [3:0] s_I;
  logic       s_CIN;
  logic       s_LOCKED, s_ERR;
  logic [7:0] s_ERR_COUNT, s_WRAPS;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int errs_seen;

  always #5 CLK = ~CLK;

  counter4_checker dut (
    .CLK(CLK), .RESET(RESET), .I(I), .CIN(CIN),
    .LOCKED(LOCKED), .ERR(ERR), .ERR_COUNT(ERR_COUNT), .WRAPS(WRAPS)
  );

  counter4_checker #(.LOCK_COUNT(1), .UNLOCK_ERRS(1000)) u_sat (
    .CLK(CLK), .RESET(s_RESET), .I(s_I), .CIN(s_CIN),
    .LOCKED(s_LOCKED), .ERR(s_ERR), .ERR_COUNT(s_ERR_COUNT), .WRAPS(s_WRAPS)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_c(input logic [3:0] v, input logic c);
    I   = v;
    CIN = c;
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [3:0] v);
    send_c(v, v == 4'hF);
  endtask

  task automatic ssend(input logic [3:0] v);
    s_I   = v;
    s_CIN = (v == 4'hF);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1; I = '0; CIN = 1'b0;
    s_RESET = 1'b1; s_I = '0; s_CIN = 1'b0;
    send(4'd0);
    send(4'd0);
    check("reset_locked", LOCKED, 0);
    check("reset_err", ERR, 0);
    check("reset_err_count", ERR_COUNT, 0);
    check("reset_wraps", WRAPS, 0);
    RESET = 1'b0;

    // Clean stream 0..39 mod 16: lock after the 5th sample, two wraps after lock.
    errs_seen = 0;
    for (int k = 0; k < 40; k++) begin
      send(4'(k));
      if (k == 3) check("A_not_locked_yet", LOCKED, 0);
      if (k == 4) check("A_locked", LOCKED, 1);
      errs_seen += int'(ERR);
    end
    check("A_no_err", errs_seen, 0);
    check("A_wraps", WRAPS, 2);
    check("A_err_count", ERR_COUNT, 0);

    // One-cycle reset mid-stream; sample 8 is swallowed by reset.
    RESET = 1'b1;
    send(4'd8);
    RESET = 1'b0;
    check("B_reset_locked", LOCKED, 0);
    check("B_reset_wraps", WRAPS, 0);
    for (int k = 9; k <= 13; k++) begin
      send(4'(k));
      if (k == 12) check("B_not_relocked_yet", LOCKED, 0);
      if (k == 13) check("B_relocked", LOCKED, 1);
    end

    // Skip 8 while locked.
    for (int k = 14; k <= 23; k++) send(4'(k));
    check("C_wraps", WRAPS, 1);
    send(4'd9);
    check("C_skip_err", ERR, 1);
    check("C_skip_err_count", ERR_COUNT, 1);
    check("C_skip_locked", LOCKED, 1);
    send(4'd10);
    check("C_after_skip_err", ERR, 0);
    check("C_after_skip_locked", LOCKED, 1);

    // Carry glitches.
    for (int k = 11; k <= 20; k++) send(4'(k));
    check("D_wraps", WRAPS, 2);
    send_c(4'd5, 1'b1);
    check("D_cin_hi_err", ERR, 1);
    check("D_cin_hi_err_count", ERR_COUNT, 2);
    check("D_cin_hi_locked", LOCKED, 1);
    for (int k = 6; k <= 14; k++) send(4'(k));
    check("D_clean_err", ERR, 0);
    send_c(4'd15, 1'b0);
    check("D_cin_lo_err", ERR, 1);
    check("D_cin_lo_err_count", ERR_COUNT, 3);
    send_c(4'd0, 1'b0);
    check("D_no_wrap_after_glitch", WRAPS, 2);
    check("D_zero_err", ERR, 0);
    check("D_zero_locked", LOCKED, 1);

    // Stuck bus at 3.
    send(4'd1); send(4'd2); send(4'd3);
    send(4'd3);
    check("E_stuck1_err", ERR, 1);
    check("E_stuck1_err_count", ERR_COUNT, 4);
    check("E_stuck1_locked", LOCKED, 1);
    send(4'd3);
    check("E_stuck2_err", ERR, 1);
    check("E_stuck2_err_count", ERR_COUNT, 5);
    check("E_stuck2_unlocked", LOCKED, 0);
    send(4'd3);
    check("E_stuck3_hunt_err", ERR, 0);
    check("E_stuck3_err_count", ERR_COUNT, 5);
    send(4'd3);
    check("E_stuck4_hunt_err", ERR, 0);
    send(4'd4); send(4'd5); send(4'd6);
    check("E_not_relocked_yet", LOCKED, 0);
    send(4'd7);
    check("E_relocked", LOCKED, 1);
    check("E_final_err_count", ERR_COUNT, 5);

    // Saturation on the LOCK_COUNT=1 instance.
    ssend(4'd0);
    s_RESET = 1'b0;
    ssend(4'd3);
    ssend(4'd4);
    check("F_locked", s_LOCKED, 1);
    check("F_err_count_start", s_ERR_COUNT, 0);
    for (int n = 1; n <= 300; n++) begin
      ssend(4'd4);
      if (n == 254) check("F_err_count_254", s_ERR_COUNT, 254);
      if (n == 255) check("F_err_count_255", s_ERR_COUNT, 255);
    end
    check("F_err_count_held", s_ERR_COUNT, 255);
    check("F_err_still_pulsing", s_ERR, 1);
    check("F_still_locked", s_LOCKED, 1);
    check("F_wraps", s_WRAPS, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
